// File: rtl/packed_occupancy_grid_if.sv
// Cell-access request/response and BRAM port bundle for packed_occupancy_grid.
// The slave modport is the grid's view of the bundle.
// The master modport is the view of the client and memory side.
interface packed_occupancy_grid_if #(
   parameter int unsigned GRID_WIDTH_LOG2  = 4,
   parameter int unsigned GRID_HEIGHT_LOG2 = 4,
   parameter int unsigned CELL_BITS        = 2,
   parameter int unsigned DATA_WIDTH       = 8,
   parameter int unsigned ADDR_WIDTH       = 6
);
   logic [GRID_WIDTH_LOG2-1:0]  cell_x;
   logic [GRID_HEIGHT_LOG2-1:0] cell_y;
   logic [1:0]                  op;
   logic [CELL_BITS-1:0]        w_value;
   logic                        vld_in;
   logic                        rdy;
   logic                        vld_out;
   logic [CELL_BITS-1:0]        r_value;
   logic                        clr;
   logic                        clr_done;
   logic [ADDR_WIDTH-1:0]       mem_addr;
   logic                        mem_we;
   logic [DATA_WIDTH-1:0]       mem_wdata;
   logic [DATA_WIDTH-1:0]       mem_rdata;

   modport slave (
      input  cell_x, cell_y, op, w_value, vld_in, clr, mem_rdata,
      output rdy, vld_out, r_value, clr_done, mem_addr, mem_we, mem_wdata
   );

   modport master (
      output cell_x, cell_y, op, w_value, vld_in, clr, mem_rdata,
      input  rdy, vld_out, r_value, clr_done, mem_addr, mem_we, mem_wdata
   );
endinterface

// File: rtl/packed_occupancy_grid.sv
// Packed multi-bit occupancy/cost grid over a single-port BRAM.
// Requests are serialised through a read-modify-write engine: RD, then MOD.
// Define PACKED_OCC_GRID_CLEAR_EN to build the hardware full-grid clear sweep.
module packed_occupancy_grid #(
   parameter int unsigned GRID_WIDTH_LOG2  = 4,
   parameter int unsigned GRID_HEIGHT_LOG2 = 4,
   parameter int unsigned CELL_BITS        = 2,
   parameter int unsigned DATA_WIDTH       = 8,
   parameter int unsigned ADDR_WIDTH       = 6
) (
   input logic                   clk,
   input logic                   rst,
   packed_occupancy_grid_if.slave bus
);
   localparam int unsigned IDX_W    = GRID_WIDTH_LOG2 + GRID_HEIGHT_LOG2;
   localparam int unsigned CPW      = DATA_WIDTH / CELL_BITS;
   localparam int unsigned CPW_LOG2 = $clog2(CPW);
   localparam int unsigned CB_LOG2  = $clog2(CELL_BITS);
   localparam int unsigned SH_W     = $clog2(DATA_WIDTH) + 1;
   localparam logic [CELL_BITS-1:0] CELL_MAX = '1;

   localparam logic [1:0] OP_READ = 2'b00;
   localparam logic [1:0] OP_WRITE = 2'b01;
   localparam logic [1:0] OP_ADD  = 2'b10;

   // Reject unsupported geometries at elaboration.
   if (!(CELL_BITS == 1 || CELL_BITS == 2 || CELL_BITS == 4 || CELL_BITS == 8)) begin : g_bad_cell
      $error("CELL_BITS must be 1, 2, 4 or 8");
   end
   if ((DATA_WIDTH < CELL_BITS) || (DATA_WIDTH % CELL_BITS != 0) || ((CPW & (CPW - 1)) != 0)) begin : g_bad_data
      $error("DATA_WIDTH must be a power-of-two multiple of CELL_BITS");
   end
   if (ADDR_WIDTH + CPW_LOG2 < IDX_W) begin : g_bad_addr
      $error("ADDR_WIDTH too small for the grid");
   end

   typedef enum logic [1:0] {
      S_IDLE,
      S_RD,
      S_MOD
`ifdef PACKED_OCC_GRID_CLEAR_EN
      , S_CLEAR
`endif
   } state_t;

   state_t                state_q, state_d;
   logic [IDX_W-1:0]      idx_q, idx_d;
   logic [1:0]            op_q, op_d;
   logic [CELL_BITS-1:0]  val_q, val_d;
   logic [CELL_BITS-1:0]  r_value_q, r_value_d;

   logic                  rdy_c, vld_out_c, mem_we_c;
   logic [CELL_BITS-1:0]  r_value_c;
   logic [ADDR_WIDTH-1:0] mem_addr_c;
   logic [DATA_WIDTH-1:0] mem_wdata_c;

   logic [IDX_W-1:0]      lane_idx;
   logic [SH_W-1:0]       sh;
   logic [ADDR_WIDTH-1:0] word_addr;
   logic [CELL_BITS-1:0]  old_cell, new_cell;
   logic [CELL_BITS:0]    sum;
   logic [DATA_WIDTH-1:0] cell_mask, merged;

`ifdef PACKED_OCC_GRID_CLEAR_EN
   localparam int unsigned NWORDS = (1 << IDX_W) / CPW;
   localparam logic [ADDR_WIDTH-1:0] LAST_WORD = ADDR_WIDTH'(NWORDS - 1);
   logic [ADDR_WIDTH-1:0] cnt_q, cnt_d;
   logic                  clr_done_q, clr_done_d;
`else
   logic unused_clr;
   assign unused_clr = bus.clr;
`endif

   // Word address, lane position and the lane merge for the latched request.
   assign lane_idx  = idx_q & IDX_W'(CPW - 1);
   assign sh        = SH_W'(lane_idx) << CB_LOG2;
   assign word_addr = ADDR_WIDTH'(idx_q >> CPW_LOG2);
   assign old_cell  = CELL_BITS'(bus.mem_rdata >> sh);
   assign cell_mask = DATA_WIDTH'(CELL_MAX) << sh;
   assign merged    = (bus.mem_rdata & ~cell_mask) | (DATA_WIDTH'(new_cell) << sh);
   assign sum       = {1'b0, old_cell} + {1'b0, val_q};

   // New cell value for write, saturating add and saturating subtract.
   always_comb begin
      new_cell = old_cell;
      case (op_q)
         OP_WRITE: new_cell = val_q;
         OP_ADD:   new_cell = sum[CELL_BITS] ? CELL_MAX : sum[CELL_BITS-1:0];
         2'b11:    new_cell = (old_cell < val_q) ? '0 : old_cell - val_q;
         default:  new_cell = old_cell;
      endcase
   end

   // Next state, request latch and BRAM/response outputs.
   always_comb begin
      state_d     = state_q;
      idx_d       = idx_q;
      op_d        = op_q;
      val_d       = val_q;
      r_value_d   = r_value_q;
      rdy_c       = 1'b0;
      vld_out_c   = 1'b0;
      r_value_c   = r_value_q;
      mem_we_c    = 1'b0;
      mem_wdata_c = '0;
      mem_addr_c  = word_addr;
`ifdef PACKED_OCC_GRID_CLEAR_EN
      cnt_d       = cnt_q;
      clr_done_d  = 1'b0;
`endif
      case (state_q)
         S_IDLE: begin
            rdy_c = 1'b1;
`ifdef PACKED_OCC_GRID_CLEAR_EN
            if (bus.clr) begin
               state_d = S_CLEAR;
               cnt_d   = '0;
            end else
`endif
            if (bus.vld_in) begin
               idx_d   = {bus.cell_y, bus.cell_x};
               op_d    = bus.op;
               val_d   = bus.w_value;
               state_d = S_RD;
            end
         end
         S_RD: begin
            state_d = S_MOD;
         end
         S_MOD: begin
            vld_out_c = 1'b1;
            r_value_c = old_cell;
            r_value_d = old_cell;
            if (op_q != OP_READ) begin
               mem_we_c    = 1'b1;
               mem_wdata_c = merged;
            end
            state_d = S_IDLE;
         end
`ifdef PACKED_OCC_GRID_CLEAR_EN
         S_CLEAR: begin
            mem_addr_c = cnt_q;
            mem_we_c   = 1'b1;
            cnt_d      = cnt_q + ADDR_WIDTH'(1);
            if (cnt_q == LAST_WORD) begin
               state_d    = S_IDLE;
               clr_done_d = 1'b1;
            end
         end
`endif
         default: state_d = S_IDLE;
      endcase
   end

   // State and request registers; reset drops any in-flight op or clear.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= S_IDLE;
         idx_q     <= '0;
         op_q      <= '0;
         val_q     <= '0;
         r_value_q <= '0;
      end else begin
         state_q   <= state_d;
         idx_q     <= idx_d;
         op_q      <= op_d;
         val_q     <= val_d;
         r_value_q <= r_value_d;
      end
   end

`ifdef PACKED_OCC_GRID_CLEAR_EN
   // Clear sweep counter and completion pulse.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_q      <= '0;
         clr_done_q <= 1'b0;
      end else begin
         cnt_q      <= cnt_d;
         clr_done_q <= clr_done_d;
      end
   end
   assign bus.clr_done = clr_done_q;
`else
   assign bus.clr_done = 1'b0;
`endif

   assign bus.rdy       = rdy_c;
   assign bus.vld_out   = vld_out_c;
   assign bus.r_value   = r_value_c;
   assign bus.mem_addr  = mem_addr_c;
   assign bus.mem_we    = mem_we_c;
   assign bus.mem_wdata = mem_wdata_c;
endmodule

// File: tb/tb_packed_occupancy_grid.sv
// Directed bench for packed_occupancy_grid with a behavioural BRAM (W=H=4, 2-bit cells, 8-bit words).
module tb_packed_occupancy_grid;
   logic clk = 1'b0;
   logic rst;
   logic mem_init;
   int   n_cmp = 0;
   int   n_fail = 0;

   packed_occupancy_grid_if #(.GRID_WIDTH_LOG2(4), .GRID_HEIGHT_LOG2(4), .CELL_BITS(2),
                              .DATA_WIDTH(8), .ADDR_WIDTH(6)) bus ();

   packed_occupancy_grid #(.GRID_WIDTH_LOG2(4), .GRID_HEIGHT_LOG2(4), .CELL_BITS(2),
                           .DATA_WIDTH(8), .ADDR_WIDTH(6)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   always #5 clk = ~clk;

   // Single-port BRAM, read-first, one-cycle registered read.
   logic [7:0] mem [64];
   always @(posedge clk) begin
      if (mem_init) begin
         for (int i = 0; i < 64; i++) mem[i] <= 8'h00;
      end else if (bus.mem_we) begin
         mem[bus.mem_addr] <= bus.mem_wdata;
      end
      bus.mem_rdata <= mem[bus.mem_addr];
   end

   initial begin
      #400000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // One request; called just after a rising edge with the DUT idle, returns in the same phase.
   task automatic op_txn(input logic [3:0] x, input logic [3:0] y, input logic [1:0] o,
                         input logic [1:0] w, output logic [1:0] rv, output logic we,
                         output logic [7:0] wd, output logic [5:0] ad, output logic got);
      int guard;
      rv = 2'd0; we = 1'b0; wd = 8'h00; ad = 6'd0; got = 1'b0;
      bus.cell_x = x; bus.cell_y = y; bus.op = o; bus.w_value = w; bus.vld_in = 1'b1;
      guard = 0;
      @(negedge clk);
      while (!bus.rdy && guard < 20) begin
         @(negedge clk);
         guard++;
      end
      if (!bus.rdy) begin
         check("accept_timeout", 32'(bus.rdy), 32'd1);
         bus.vld_in = 1'b0;
         @(posedge clk); #1;
         return;
      end
      @(posedge clk); #1;
      bus.vld_in = 1'b0;
      bus.cell_x = 4'hA; bus.cell_y = 4'hA; bus.op = 2'b00; bus.w_value = 2'b00;
      @(negedge clk);
      @(negedge clk);
      got = bus.vld_out; rv = bus.r_value; we = bus.mem_we; wd = bus.mem_wdata; ad = bus.mem_addr;
      @(posedge clk); #1;
   endtask

   typedef struct {
      logic [3:0] x, y;
      logic [1:0] op, w, rv;
      logic       we;
      logic [7:0] wd;
      logic [5:0] ad;
   } vec_t;

   vec_t vecs[19];
   logic [1:0] rv;
   logic       we, got;
   logic [7:0] wd;
   logic [5:0] ad;
   logic [8:0] rdy_seen, vld_seen;
   int         bad, nwr, ro_low;
   logic       vld_during, done_seen;

   initial begin
      vecs[0]  = '{4'd5,  4'd2,  2'd1, 2'd3, 2'd0, 1'b1, 8'h0C, 6'd9};
      vecs[1]  = '{4'd5,  4'd2,  2'd0, 2'd0, 2'd3, 1'b0, 8'h00, 6'd9};
      vecs[2]  = '{4'd4,  4'd2,  2'd0, 2'd0, 2'd0, 1'b0, 8'h00, 6'd9};
      vecs[3]  = '{4'd6,  4'd2,  2'd0, 2'd0, 2'd0, 1'b0, 8'h00, 6'd9};
      vecs[4]  = '{4'd7,  4'd2,  2'd0, 2'd0, 2'd0, 1'b0, 8'h00, 6'd9};
      vecs[5]  = '{4'd1,  4'd0,  2'd1, 2'd2, 2'd0, 1'b1, 8'h08, 6'd0};
      vecs[6]  = '{4'd1,  4'd0,  2'd2, 2'd2, 2'd2, 1'b1, 8'h0C, 6'd0};
      vecs[7]  = '{4'd1,  4'd0,  2'd0, 2'd0, 2'd3, 1'b0, 8'h00, 6'd0};
      vecs[8]  = '{4'd3,  4'd3,  2'd1, 2'd1, 2'd0, 1'b1, 8'h40, 6'd12};
      vecs[9]  = '{4'd3,  4'd3,  2'd3, 2'd3, 2'd1, 1'b1, 8'h00, 6'd12};
      vecs[10] = '{4'd3,  4'd3,  2'd0, 2'd0, 2'd0, 1'b0, 8'h00, 6'd12};
      vecs[11] = '{4'd15, 4'd15, 2'd2, 2'd1, 2'd0, 1'b1, 8'h40, 6'd63};
      vecs[12] = '{4'd15, 4'd15, 2'd2, 2'd1, 2'd1, 1'b1, 8'h80, 6'd63};
      vecs[13] = '{4'd5,  4'd2,  2'd1, 2'd3, 2'd3, 1'b1, 8'h0C, 6'd9};
      vecs[14] = '{4'd5,  4'd2,  2'd3, 2'd1, 2'd3, 1'b1, 8'h08, 6'd9};
      vecs[15] = '{4'd5,  4'd2,  2'd0, 2'd0, 2'd2, 1'b0, 8'h00, 6'd9};
      vecs[16] = '{4'd0,  4'd0,  2'd2, 2'd0, 2'd0, 1'b1, 8'h0C, 6'd0};
      vecs[17] = '{4'd2,  4'd0,  2'd2, 2'd3, 2'd0, 1'b1, 8'h3C, 6'd0};
      vecs[18] = '{4'd2,  4'd0,  2'd2, 2'd1, 2'd3, 1'b1, 8'h3C, 6'd0};

      rst = 1'b1; mem_init = 1'b1;
      bus.cell_x = 4'd0; bus.cell_y = 4'd0; bus.op = 2'd0; bus.w_value = 2'd0;
      bus.vld_in = 1'b0; bus.clr = 1'b0;
      @(posedge clk); @(posedge clk);
      @(negedge clk);
      check("rst_rdy",       32'(bus.rdy),       32'd1);
      check("rst_vld_out",   32'(bus.vld_out),   32'd0);
      check("rst_r_value",   32'(bus.r_value),   32'd0);
      check("rst_clr_done",  32'(bus.clr_done),  32'd0);
      check("rst_mem_addr",  32'(bus.mem_addr),  32'd0);
      check("rst_mem_we",    32'(bus.mem_we),    32'd0);
      check("rst_mem_wdata", 32'(bus.mem_wdata), 32'd0);
      @(posedge clk); #1;
      rst = 1'b0; mem_init = 1'b0;
      @(posedge clk); #1;

      // Table of single operations against a zeroed memory.
      for (int i = 0; i < 19; i++) begin
         op_txn(vecs[i].x, vecs[i].y, vecs[i].op, vecs[i].w, rv, we, wd, ad, got);
         check($sformatf("v%0d_vld_out", i), 32'(got), 32'd1);
         check($sformatf("v%0d_r_value", i), 32'(rv), 32'(vecs[i].rv));
         check($sformatf("v%0d_mem_we", i), 32'(we), 32'(vecs[i].we));
         check($sformatf("v%0d_mem_addr", i), 32'(ad), 32'(vecs[i].ad));
         if (vecs[i].we) check($sformatf("v%0d_mem_wdata", i), 32'(wd), 32'(vecs[i].wd));
      end

      // Back-to-back reads with vld_in held high: one accept every 3 cycles.
      bus.cell_x = 4'd5; bus.cell_y = 4'd2; bus.op = 2'd0; bus.w_value = 2'd0; bus.vld_in = 1'b1;
      rdy_seen = '0; vld_seen = '0;
      for (int c = 0; c < 9; c++) begin
         @(negedge clk);
         rdy_seen[c] = bus.rdy;
         vld_seen[c] = bus.vld_out;
         if (bus.vld_out) check($sformatf("tput_r_value_c%0d", c), 32'(bus.r_value), 32'd2);
         @(posedge clk); #1;
         if (c == 6) bus.vld_in = 1'b0;
      end
      check("tput_rdy_pattern", 32'(rdy_seen), 32'h049);
      check("tput_vld_pattern", 32'(vld_seen), 32'h124);

`ifdef PACKED_OCC_GRID_CLEAR_EN
      // Clear requested together with a read: the clear wins and sweeps all 64 words.
      bus.clr = 1'b1; bus.vld_in = 1'b1; bus.op = 2'd0;
      @(posedge clk); #1;
      bus.clr = 1'b0; bus.vld_in = 1'b0;
      nwr = 0; ro_low = 0; bad = 0; vld_during = 1'b0; done_seen = 1'b0;
      for (int c = 1; c <= 70; c++) begin
         @(negedge clk);
         if (bus.clr_done) begin
            done_seen = 1'b1;
            check("clr_done_cycle", 32'(c), 32'd65);
            check("clr_done_rdy", 32'(bus.rdy), 32'd1);
            @(posedge clk); #1;
            break;
         end
         if (!bus.rdy) ro_low++;
         if (bus.vld_out) vld_during = 1'b1;
         if (bus.mem_we) begin
            if (bus.mem_addr != 6'(c - 1) || bus.mem_wdata != 8'h00) bad++;
            nwr++;
         end
         @(posedge clk); #1;
      end
      check("clr_seen", 32'(done_seen), 32'd1);
      check("clr_writes", 32'(nwr), 32'd64);
      check("clr_rdy_low", 32'(ro_low), 32'd64);
      check("clr_addr_seq", 32'(bad), 32'd0);
      check("clr_no_vld_out", 32'(vld_during), 32'd0);
      @(negedge clk);
      check("clr_done_pulse", 32'(bus.clr_done), 32'd0);
      @(posedge clk); #1;
      bad = 0;
      for (int i = 0; i < 256; i++) begin
         op_txn(4'(i % 16), 4'(i / 16), 2'd0, 2'd0, rv, we, wd, ad, got);
         if (!got || rv != 2'd0) bad++;
      end
      check("clr_all_zero", 32'(bad), 32'd0);
`else
      // Clear is not built: clr must have no effect.
      bus.clr = 1'b1;
      @(posedge clk); #1;
      bus.clr = 1'b0;
      nwr = 0; ro_low = 0; done_seen = 1'b0;
      for (int c = 0; c < 70; c++) begin
         @(negedge clk);
         if (!bus.rdy) ro_low++;
         if (bus.clr_done) done_seen = 1'b1;
         if (bus.mem_we) nwr++;
         @(posedge clk); #1;
      end
      check("noclr_rdy_low", 32'(ro_low), 32'd0);
      check("noclr_clr_done", 32'(done_seen), 32'd0);
      check("noclr_writes", 32'(nwr), 32'd0);
      op_txn(4'd5, 4'd2, 2'd0, 2'd0, rv, we, wd, ad, got);
      check("noclr_keep_5_2", 32'(rv), 32'd2);
      op_txn(4'd2, 4'd0, 2'd0, 2'd0, rv, we, wd, ad, got);
      check("noclr_keep_2_0", 32'(rv), 32'd3);
      op_txn(4'd15, 4'd15, 2'd0, 2'd0, rv, we, wd, ad, got);
      check("noclr_keep_15_15", 32'(rv), 32'd2);
`endif

      // Reset during the MOD cycle of a write drops the op and its BRAM write.
      op_txn(4'd0, 4'd0, 2'd1, 2'd2, rv, we, wd, ad, got);
      op_txn(4'd0, 4'd0, 2'd1, 2'd3, rv, we, wd, ad, got);
      check("rstmod_setup_rv", 32'(rv), 32'd2);
      bus.cell_x = 4'd0; bus.cell_y = 4'd0; bus.op = 2'd1; bus.w_value = 2'd1; bus.vld_in = 1'b1;
      @(negedge clk);
      check("rstmod_accept", 32'(bus.rdy), 32'd1);
      @(posedge clk); #1;
      bus.vld_in = 1'b0;
      @(posedge clk); #1;
      check("rstmod_we_before", 32'(bus.mem_we), 32'd1);
      #1 rst = 1'b1;
      #1;
      check("rstmod_mem_we",    32'(bus.mem_we),    32'd0);
      check("rstmod_vld_out",   32'(bus.vld_out),   32'd0);
      check("rstmod_rdy",       32'(bus.rdy),       32'd1);
      check("rstmod_r_value",   32'(bus.r_value),   32'd0);
      check("rstmod_mem_wdata", 32'(bus.mem_wdata), 32'd0);
      @(posedge clk); #1;
      @(negedge clk);
      check("rstmod_vld_hold", 32'(bus.vld_out), 32'd0);
      @(posedge clk); #1;
      rst = 1'b0;
      @(posedge clk); #1;
      op_txn(4'd0, 4'd0, 2'd0, 2'd0, rv, we, wd, ad, got);
      check("rstmod_old_kept", 32'(rv), 32'd3);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end
endmodule

// File: doc/packed_occupancy_grid.md
# packed_occupancy_grid

Multi-bit occupancy/cost grid that packs `CELL_BITS`-wide cells into word-wide single-port BRAM and serialises read, write and saturating increment/decrement requests through a read-modify-write engine. It is the generalised successor of the 1-bit occupancy grid. It sits between the planner's cell-access clients and one `bram` instance. An optional sweep engine clears the whole grid in hardware.

## Interface
Parameters:
- `GRID_WIDTH_LOG2`, default 4: log2 of grid columns.
- `GRID_HEIGHT_LOG2`, default 4: log2 of grid rows.
- `CELL_BITS`, default 2: bits per cell. Must be 1, 2, 4 or 8.
- `DATA_WIDTH`, default 8: BRAM word width. Must be a power-of-two multiple of `CELL_BITS`. `CPW = DATA_WIDTH/CELL_BITS` cells per word.
- `ADDR_WIDTH`, default 6: BRAM address width. Must satisfy `ADDR_WIDTH >= GRID_WIDTH_LOG2+GRID_HEIGHT_LOG2-log2(CPW)`; an elaboration error is raised otherwise.

Ports:
- `clk` in 1: single clock; all logic is rising-edge.
- `rst` in 1: asynchronous, active-high reset.
- `cell_x` in `GRID_WIDTH_LOG2`: column.
- `cell_y` in `GRID_HEIGHT_LOG2`: row.
- `op` in 2: operation. 00 read, 01 write, 10 saturating add, 11 saturating subtract.
- `w_value` in `CELL_BITS`: write value or delta.
- `vld_in` in 1: request valid.
- `rdy` out 1: request accepted when `vld_in && rdy`.
- `vld_out` out 1: one-cycle completion pulse.
- `r_value` out `CELL_BITS`: cell value before the operation. Valid with `vld_out`; held otherwise.
- `clr` in 1: start a full-grid clear.
- `clr_done` out 1: one-cycle pulse at the end of a clear.
- `mem_addr` out `ADDR_WIDTH`, `mem_we` out 1, `mem_wdata` out `DATA_WIDTH`: BRAM request.
- `mem_rdata` in `DATA_WIDTH`: BRAM read data, one-cycle registered latency.

## Operation
- Linear index `idx = {cell_y, cell_x}` (row-major).
- Word address `= idx >> log2(CPW)`.
- Lane `= idx[log2(CPW)-1:0]`; the cell occupies bits `[lane*CELL_BITS +: CELL_BITS]`.
- Inputs are captured on accept; they may change afterwards.

State machine:
- IDLE: `rdy=1`, `mem_we=0`.
  - `clr` is high: go to CLEAR (only with the macro). `clr` has priority over `vld_in`.
  - Otherwise, `vld_in` is high: latch the request and go to RD.
- RD: drive `mem_addr` = word address, `mem_we=0`. Go to MOD.
- MOD: `mem_rdata` is valid. Extract `old`, then:
  - `r_value <= old`, `vld_out=1`.
  - op 00: no write.
  - op 01: `new = w_value`.
  - op 10: `new = min(old + w_value, 2^CELL_BITS - 1)`, computed at `CELL_BITS+1` width.
  - op 11: `new = max(old - w_value, 0)`.
  - For ops 01/10/11: `mem_we=1`, `mem_wdata` = read word with only the target lane replaced, same `mem_addr`.
  - Go to IDLE.
- CLEAR: `rdy=0`. Each cycle write all-zero to `mem_addr = cnt` and increment `cnt`. After writing the last word `2^(GRID_WIDTH_LOG2+GRID_HEIGHT_LOG2)/CPW - 1`, pulse `clr_done` on the next cycle and go to IDLE.

Boundary rules:
- Saturation at the maximum value and at 0 is a normal completion with no error flag.
- A write of an unchanged value still performs the BRAM write.
- Reset asserted in any state:
  - Immediately forces IDLE, `mem_we=0`, and zeroes all outputs except `rdy=1`.
  - An in-flight op is dropped: no `vld_out`, and no write if reset arrives at or before MOD.
  - A clear in progress is aborted: the grid is partially cleared and no `clr_done` is issued.
- Memory contents are not reset.

## Timing
- Reset values: `rdy=1`, `vld_out=0`, `r_value=0`, `clr_done=0`, `mem_addr=0`, `mem_we=0`, `mem_wdata=0`.
- Accept at cycle 0 (IDLE): RD in cycle 1, MOD with `vld_out` and any write in cycle 2, `rdy` high again in cycle 3.
- Latency is 2 cycles for every op. Throughput is one op per 3 cycles.
- Ops are strictly serialised, so there are no read-after-write hazards.
- Clear: `clr` accepted at cycle 0, writes in cycles 1..N where N = word count, `clr_done` and `rdy` high at cycle N+1.

## Configuration
- `PACKED_OCC_GRID_CLEAR_EN` defined: CLEAR state, counter and `clr_done` are built.
- Not defined: `clr` is ignored, `clr_done` is tied to 0, and no CLEAR logic is synthesised.

## Test plan
Parameters for all scenarios: W=4, H=4, `CELL_BITS=2`, `DATA_WIDTH=8`, `ADDR_WIDTH=6`, macro defined.
- Write 3 to (5,2), then read (5,2), (4,2), (6,2), (7,2). Expect `r_value` 3, 0, 0, 0; all four cells are in word 9; the write cycle shows `mem_wdata=8'h0C`.
- Saturation:
  - Cell value 2, add 2: `r_value=2`, then reads back 3.
  - Cell value 1, subtract 3: `r_value=1`, then reads back 0.
- Hold `vld_in=1` for 3 reads. Expect accepts at cycles 0, 3, 6, `vld_out` at cycles 2, 5, 8, and `rdy` low in cycles 1-2, 4-5, 7-8.
- After several writes, pulse `clr` together with `vld_in`. Expect the clear to win, `rdy` low for 64 write cycles, `clr_done` at cycle 65, then all 256 cells read 0.
- Assert `rst` during the MOD cycle of a write to (0,0). Expect `mem_we` to fall that cycle, no `vld_out`, `rdy=1`, and (0,0) to read its old value after release.
- Rebuild without the macro and pulse `clr`. Expect `rdy` to stay 1, `clr_done` to stay 0, and memory to be unchanged.
